// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: enables, flushes
// and bubbles for every pipeline register, plus a front-end stall counter.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        ex_redirect,
  input  logic        md_start,
  input  logic        mem_wait,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        exmem_bubble,
  output logic        memwb_en,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_q, stall_d;

  logic load_use;
  logic pc_en_c, ifid_en_c, ifid_flush_c;
  logic idex_en_c, idex_bubble_c;
  logic exmem_en_c, exmem_bubble_c;
  logic memwb_en_c, md_done_c;

  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) ||
                     (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_en_c        = 1'b1;
    ifid_en_c      = 1'b1;
    ifid_flush_c   = 1'b0;
    idex_en_c      = 1'b1;
    idex_bubble_c  = 1'b0;
    exmem_en_c     = 1'b1;
    exmem_bubble_c = 1'b0;
    memwb_en_c     = 1'b1;
    md_done_c      = 1'b0;
    if (mem_wait) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        pc_en_c        = 1'b0;
        ifid_en_c      = 1'b0;
        idex_en_c      = 1'b0;
        exmem_bubble_c = 1'b1;
        cnt_d          = cnt_q - 1'b1;
      end else begin
        md_done_c = 1'b1;
        state_d   = RUN;
      end
    end else if (ex_redirect) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (md_start) begin
      // EX is held; bubbles drain downstream while the unit works
      pc_en_c        = 1'b0;
      ifid_en_c      = 1'b0;
      idex_en_c      = 1'b0;
      exmem_bubble_c = 1'b1;
      cnt_d          = MD_LOAD;
      state_d        = BUSY;
    end else if (load_use) begin
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_bubble_c = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en_c && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Reset forces a safe, fully frozen and bubbled pipeline
  always_comb begin
    pc_en        = reset & pc_en_c;
    ifid_en      = reset & ifid_en_c;
    ifid_flush   = reset & ifid_flush_c;
    idex_en      = reset & idex_en_c;
    idex_bubble  = ~reset | idex_bubble_c;
    exmem_en     = reset & exmem_en_c;
    exmem_bubble = ~reset | exmem_bubble_c;
    memwb_en     = reset & memwb_en_c;
    md_done      = reset & md_done_c;
    md_busy      = reset & (state_q == BUSY);
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares against both DUT instances.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_memread;
  logic       ex_redirect, md_start, mem_wait;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic        exmem_en, exmem_bubble, memwb_en, md_busy, md_done;
  logic [15:0] stall_cnt;

  logic        pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_bubble2;
  logic        exmem_en2, exmem_bubble2, memwb_en2, md_busy2, md_done2;
  logic [15:0] stall_cnt2;

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ex_redirect(ex_redirect), .md_start(md_start),
    .mem_wait(mem_wait),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .exmem_bubble(exmem_bubble),
    .memwb_en(memwb_en), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MD_LAT(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ex_redirect(ex_redirect), .md_start(md_start),
    .mem_wait(mem_wait),
    .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2),
    .idex_en(idex_en2), .idex_bubble(idex_bubble2),
    .exmem_en(exmem_en2), .exmem_bubble(exmem_bubble2),
    .memwb_en(memwb_en2), .md_busy(md_busy2), .md_done(md_done2),
    .stall_cnt(stall_cnt2)
  );

  // {pc,ifid,flush,idex,ibub,exmem,ebub,memwb,busy,done}
  localparam logic [9:0] NORM = 10'b1101010100;
  localparam logic [9:0] LU   = 10'b0001110100;
  localparam logic [9:0] RD   = 10'b1111110100;
  localparam logic [9:0] MDS  = 10'b0000011100;
  localparam logic [9:0] MDB  = 10'b0000011110;
  localparam logic [9:0] DONE = 10'b1101010111;
  localparam logic [9:0] FRZ  = 10'b0000000000;
  localparam logic [9:0] FRZB = 10'b0000000010;
  localparam logic [9:0] RST  = 10'b0000101000;

  typedef struct {
    string       name;
    logic [9:0]  o;
    logic [15:0] sc;
    logic        chk2;
    logic [2:0]  o2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string nm, input logic [9:0] eo,
                      input logic [15:0] esc,
                      input logic c2 = 1'b0,
                      input logic [2:0] e2 = 3'b000);
    exp_t e;
    e.name = nm;
    e.o    = eo;
    e.sc   = esc;
    e.chk2 = c2;
    e.o2   = e2;
    q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr,
                       input logic [4:0] xrt, input logic rd,
                       input logic md, input logic mw);
    ifid_rs      = rs;
    ifid_rt      = rt;
    ifid_uses_rt = urt;
    idex_memread = mr;
    idex_rt      = xrt;
    ex_redirect  = rd;
    md_start     = md;
    mem_wait     = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] a;
      logic [2:0] a2;
      e  = q.pop_front();
      a  = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
            exmem_en, exmem_bubble, memwb_en, md_busy, md_done};
      a2 = {pc_en2, md_busy2, md_done2};
      checks++;
      if (a !== e.o) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b", e.name, a, e.o);
      end
      checks++;
      if (stall_cnt !== e.sc) begin
        errors++;
        $display("FAIL %s stall_cnt got %h want %h",
                 e.name, stall_cnt, e.sc);
      end
      if (e.chk2) begin
        checks++;
        if (a2 !== e.o2) begin
          errors++;
          $display("FAIL %s lat2 {pc,busy,done} got %b want %b",
                   e.name, a2, e.o2);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    push("reset", RST, 16'h0); tick();
    reset = 1'b1;
    push("idle", NORM, 16'd0); tick();
    // load-use via rs
    drive(5, 0, 0, 1, 5, 0, 0, 0);
    push("lu_rs", LU, 16'd0); tick();
    drive(5, 0, 0, 0, 5, 0, 0, 0);
    push("lu_after", NORM, 16'd1); tick();
    // load-use via rt
    drive(0, 7, 1, 1, 7, 0, 0, 0);
    push("lu_rt", LU, 16'd1); tick();
    drive(0, 7, 0, 1, 7, 0, 0, 0);
    push("rt_unused", NORM, 16'd2); tick();
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    push("rt_zero", NORM, 16'd2); tick();
    // redirect beats load-use
    drive(5, 0, 0, 1, 5, 1, 0, 0);
    push("redir_lu", RD, 16'd2); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("idle2", NORM, 16'd2); tick();
    // mult/div, latency 4 (and 2 on dut2)
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    push("md_c1", MDS, 16'd2, 1'b1, 3'b000); tick();
    push("md_c2", MDB, 16'd3, 1'b1, 3'b111); tick();
    push("md_c3", MDB, 16'd4); tick();
    push("md_c4", DONE, 16'd5); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("md_c5", NORM, 16'd5); tick();
    // mem_wait in the middle of BUSY
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    push("mw_c1", MDS, 16'd5); tick();
    push("mw_c2", MDB, 16'd6); tick();
    mem_wait = 1'b1;
    push("mw_c3", FRZB, 16'd7); tick();
    push("mw_c4", FRZB, 16'd8); tick();
    mem_wait = 1'b0;
    push("mw_c5", MDB, 16'd9); tick();
    push("mw_c6", DONE, 16'd10); tick();
    md_start = 1'b0;
    push("mw_c7", NORM, 16'd10); tick();
    // asynchronous reset mid-BUSY
    md_start = 1'b1;
    push("rb_c1", MDS, 16'd10); tick();
    push("rb_c2", MDB, 16'd11); tick();
    #2;
    reset = 1'b0;
    push("rb_async", RST, 16'd0); tick();
    reset = 1'b1;
    md_start = 1'b0;
    push("rb_after", NORM, 16'd0); tick();
    // saturation
    mem_wait = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    push("sat_hold", FRZ, 16'hFFFF); tick();
    mem_wait = 1'b0;
    push("sat_run", NORM, 16'hFFFF); tick();
    tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, branch/jump redirects, multi-cycle multiply/divide occupancy of EX, and data-memory wait states. It also keeps a saturating front-end stall-cycle counter.

## Interface
Parameters:
- MD_LAT, 4: total cycles a mult/div instruction occupies EX; legal range 2..(2^CNT_W+1).
- CNT_W, 4: width of the internal mult/div countdown counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifid_rs  in  5  rs field of the instruction in ID.
- ifid_rt  in  5  rt field of the instruction in ID.
- ifid_uses_rt  in  1  the instruction in ID reads rt as a source.
- idex_memread  in  1  the instruction in EX is a load.
- idex_rt  in  5  destination rt of the instruction in EX.
- ex_redirect  in  1  the instruction in EX is a taken branch or a jump.
- md_start  in  1  the instruction in EX is mult/div; stays high while it is held in EX.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  load zero WB/MEM/EX control fields into ID/EX.
- exmem_en  out  1  EX/MEM load enable.
- exmem_bubble  out  1  load zero control fields into EX/MEM.
- memwb_en  out  1  MEM/WB load enable.
- md_busy  out  1  the controller is in state BUSY.
- md_done  out  1  one-cycle pulse on the last EX cycle of a mult/div.
- stall_cnt  out  16  saturating count of cycles with pc_en=0.

## Operation
- States: RUN and BUSY; mult/div countdown cnt (CNT_W bits).
- load_use = idex_memread and idex_rt≠0 and (idex_rt==ifid_rs or (ifid_uses_rt and idex_rt==ifid_rt)).
- Outputs are combinational from state, cnt and inputs. They are evaluated in the priority order below; the first matching rule applies.
  1. mem_wait=1, any state: all *_en=0, all flush/bubble=0, md_done=0. State and cnt hold.
  2. BUSY, cnt≠0: pc_en=ifid_en=idex_en=0, exmem_bubble=1, exmem_en=memwb_en=1. cnt decrements.
  3. BUSY, cnt==0: all enables 1, no flush/bubble, md_done=1. Next state is RUN.
  4. RUN, ex_redirect=1: all enables 1, ifid_flush=1, idex_bubble=1. md_start and load_use are ignored.
  5. RUN, md_start=1: same outputs as rule 2. cnt is loaded with MD_LAT-2 and the next state is BUSY.
  6. RUN, load_use=1: pc_en=ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=memwb_en=1.
  7. Otherwise: all enables 1, no flush/bubble.
- md_start is ignored in BUSY. md_busy=1 exactly when the state is BUSY.
- stall_cnt increments by 1 on each edge where pc_en=0, including mem_wait cycles. It saturates at 0xFFFF.
- While reset=0: state=RUN, cnt=0, stall_cnt=0. Outputs are forced to all *_en=0, ifid_flush=0, idex_bubble=1, exmem_bubble=1, md_busy=0, md_done=0.

## Timing
- A load-use hazard costs exactly 1 stall cycle. The bubble lands in ID/EX at the edge ending the hazard cycle, so load_use deasserts in the next cycle.
- A redirect costs 2 squashed slots (IF/ID and ID/EX), both cleared at the same edge at which the PC loads the target.
- A mult/div holds EX for exactly MD_LAT cycles, counting from the first cycle md_start is seen in RUN. md_done is asserted in cycle MD_LAT. The front end resumes at the edge ending that cycle.
- mem_wait stretches every state in place. A BUSY sequence resumes with the same cnt after mem_wait falls.
- Reset asserted mid-BUSY aborts the sequence immediately (asynchronous). After release, the controller is in RUN.
- There are no registered outputs other than md_busy (state-decoded) and stall_cnt.

## Test plan
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 for one cycle, then idex_memread=0 -> a single cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt increments 0→1. The same stimulus with idex_rt=0 -> no stall.
- Redirect over load-use: ex_redirect=1 and load_use=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1; stall_cnt unchanged.
- Mult/div, MD_LAT=4: md_start high for 4 cycles -> pc_en=0 in cycles 1-3, exmem_bubble=1 in cycles 1-3, md_busy=1 in cycles 2-4, md_done=1 only in cycle 4, pc_en=1 in cycle 4. The same run with MD_LAT=2 -> md_done in cycle 2.
- mem_wait pulsed for 2 cycles in the middle of BUSY (MD_LAT=4) -> all enables 0 during the pulse; md_done is delayed by exactly 2 cycles; stall_cnt advances by 5 in total.
- Reset asserted asynchronously, between clock edges, during BUSY -> md_busy=0 and idex_bubble=1 immediately. After release, the next cycle has all enables 1 and stall_cnt=0.
- Saturation: force pc_en=0 for 65540 cycles via mem_wait -> stall_cnt holds at 0xFFFF.
